shift_arbiter: RTL and testbench

SHIFT_ARBITER -- requirements
Module: shift_arbiter

---
 rtl/shift_arbiter.sv | 127 ++++++++++++
 tb/tb_shift_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_arbiter.sv
// shift_arbiter: two-requester round-robin front end for a single 64-bit
// barrel shifter with a one-entry registered result and per-requester
// saturating grant counters.
module shift_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [63:0]      req0_a,
    input  logic [5:0]       req0_n,
    input  logic [1:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [63:0]      req1_a,
    input  logic [5:0]       req1_n,
    input  logic [1:0]       req1_op,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [63:0]      res_data,
    output logic             res_id,
    output logic [CNT_W-1:0] gnt0_cnt,
    output logic [CNT_W-1:0] gnt1_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_rr;
    logic [63:0]        r_res_data;
    logic               r_res_id;
    logic [CNT_W-1:0]   r_gnt0_cnt;
    logic [CNT_W-1:0]   r_gnt1_cnt;

    logic               w_window;
    logic               w_gnt0;
    logic               w_gnt1;
    logic               w_accept;
    logic [63:0]        w_sel_a;
    logic [5:0]         w_sel_n;
    logic [1:0]         w_sel_op;

    // Shift unit: SLL / SRL zero fill, SRA sign fill, reserved op yields zero.
    function automatic logic [63:0] f_shift(input logic [63:0] a,
                                            input logic [5:0]  n,
                                            input logic [1:0]  op);
        logic [63:0] y;
        case (op)
            2'b00:   y = a << n;
            2'b01:   y = a >> n;
            2'b10:   y = $unsigned($signed(a) >>> n);
            default: y = 64'h0;
        endcase
        return y;
    endfunction

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] c);
        logic [CNT_W-1:0] y;
        if (&c) y = c;
        else    y = c + {{(CNT_W-1){1'b0}}, 1'b1};
        return y;
    endfunction

    // Window opens when the result slot is empty or being drained this cycle;
    // reset closes it so nothing is accepted during a reset cycle.
    assign w_window = !reset && ((r_state == IDLE) || res_ready);
    assign w_gnt0   = w_window && req0_valid && (!req1_valid || (r_rr == 1'b0));
    assign w_gnt1   = w_window && req1_valid && (!req0_valid || (r_rr == 1'b1));
    assign w_accept = w_gnt0 || w_gnt1;

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    assign w_sel_a  = w_gnt1 ? req1_a  : req0_a;
    assign w_sel_n  = w_gnt1 ? req1_n  : req0_n;
    assign w_sel_op = w_gnt1 ? req1_op : req0_op;

    assign res_valid = (r_state == HOLD);
    assign res_data  = r_res_data;
    assign res_id    = r_res_id;
    assign gnt0_cnt  = r_gnt0_cnt;
    assign gnt1_cnt  = r_gnt1_cnt;

    // Next-state logic: a new acceptance always lands in HOLD; a stalled
    // result stays in HOLD; otherwise the slot empties.
    always_comb begin
        w_state_nxt = IDLE;
        if (w_accept) begin
            w_state_nxt = HOLD;
        end else if ((r_state == HOLD) && !res_ready) begin
            w_state_nxt = HOLD;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Result slot, round-robin pointer and grant counters update on acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr       <= 1'b0;
            r_res_data <= 64'h0;
            r_res_id   <= 1'b0;
            r_gnt0_cnt <= '0;
            r_gnt1_cnt <= '0;
        end else if (w_accept) begin
            r_rr       <= w_gnt0;
            r_res_data <= f_shift(w_sel_a, w_sel_n, w_sel_op);
            r_res_id   <= w_gnt1;
            if (w_gnt0) r_gnt0_cnt <= f_sat_inc(r_gnt0_cnt);
            if (w_gnt1) r_gnt1_cnt <= f_sat_inc(r_gnt1_cnt);
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter: directed stimulus with a queue-based scoreboard; a
// monitor pops expected results whenever a result is consumed.
module tb_shift_arbiter;

    logic        clk;
    logic        reset;
    logic        req0_valid, req0_ready;
    logic [63:0] req0_a;
    logic [5:0]  req0_n;
    logic [1:0]  req0_op;
    logic        req1_valid, req1_ready;
    logic [63:0] req1_a;
    logic [5:0]  req1_n;
    logic [1:0]  req1_op;
    logic        res_valid, res_ready;
    logic [63:0] res_data;
    logic        res_id;
    logic [15:0] gnt0_cnt, gnt1_cnt;

    // Second instance with narrow counters for saturation checks.
    logic        rst2, v2, d2_rdy0, d2_rdy1, d2_res_valid, d2_res_id, d2_res_ready;
    logic [63:0] d2_res_data;
    logic [1:0]  d2_cnt0, d2_cnt1;
    logic        d2_v1;

    typedef struct {
        logic        id;
        logic [63:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    shift_arbiter #(.CNT_W(16)) u_dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_n(req0_n), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_n(req1_n), .req1_op(req1_op),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_id(res_id),
        .gnt0_cnt(gnt0_cnt), .gnt1_cnt(gnt1_cnt)
    );

    shift_arbiter #(.CNT_W(2)) u_dut2 (
        .clk(clk), .reset(rst2),
        .req0_valid(v2), .req0_ready(d2_rdy0),
        .req0_a(req0_a), .req0_n(req0_n), .req0_op(req0_op),
        .req1_valid(d2_v1), .req1_ready(d2_rdy1),
        .req1_a(req1_a), .req1_n(req1_n), .req1_op(req1_op),
        .res_valid(d2_res_valid), .res_ready(d2_res_ready),
        .res_data(d2_res_data), .res_id(d2_res_id),
        .gnt0_cnt(d2_cnt0), .gnt1_cnt(d2_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic id, input logic [63:0] data);
        exp_t e;
        e.id   = id;
        e.data = data;
        sb_q.push_back(e);
    endtask

    // Monitor: every consumed result must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && res_valid && res_ready) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: got id=%0d data=%h expected none", res_id, res_data);
                end else begin
                    e = sb_q.pop_front();
                    chk("res_id", {63'h0, res_id}, {63'h0, e.id});
                    chk("res_data", res_data, e.data);
                end
            end
        end
    end

    // Watchdog.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] sat_exp [5];
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        reset = 1'b1; rst2 = 1'b1; v2 = 1'b0; d2_v1 = 1'b0; d2_res_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 64'h0; req0_n = 6'd0; req0_op = 2'b00;
        req1_valid = 1'b0; req1_a = 64'h0; req1_n = 6'd0; req1_op = 2'b00;
        res_ready = 1'b0;
        step(); step();

        // Reset state
        chk("rst_res_valid", {63'h0, res_valid}, 64'h0);
        chk("rst_res_data", res_data, 64'h0);
        chk("rst_res_id", {63'h0, res_id}, 64'h0);
        chk("rst_gnt0", {48'h0, gnt0_cnt}, 64'h0);
        chk("rst_gnt1", {48'h0, gnt1_cnt}, 64'h0);
        chk("rst_ready0", {63'h0, req0_ready}, 64'h0);

        // SRA of negative value by 4
        reset = 1'b0; res_ready = 1'b1;
        req0_a = 64'h8000_0000_0000_0000; req0_n = 6'd4; req0_op = 2'b10;
        #1;
        chk("A_ready0", {63'h0, req0_ready}, 64'h1);
        push(1'b0, 64'hF800_0000_0000_0000);
        step();
        req0_valid = 1'b0;
        chk("A_res_valid", {63'h0, res_valid}, 64'h1);
        chk("A_gnt0", {48'h0, gnt0_cnt}, 64'h1);
        step();
        chk("A_drained", {63'h0, res_valid}, 64'h0);

        // Both valid every cycle from reset: alternate 0,1,0,1
        reset = 1'b1; step(); reset = 1'b0;
        req0_a = 64'h1;  req0_n = 6'd4; req0_op = 2'b00;
        req1_a = 64'hF0; req1_n = 6'd4; req1_op = 2'b01;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("B_ready0", {63'h0, req0_ready}, (k % 2 == 0) ? 64'h1 : 64'h0);
            chk("B_ready1", {63'h0, req1_ready}, (k % 2 == 1) ? 64'h1 : 64'h0);
            if (k % 2 == 0) push(1'b0, 64'h10);
            else            push(1'b1, 64'hF);
            step();
            chk("B_res_valid", {63'h0, res_valid}, 64'h1);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("B_gnt0", {48'h0, gnt0_cnt}, 64'h2);
        chk("B_gnt1", {48'h0, gnt1_cnt}, 64'h2);
        step();
        chk("B_drained", {63'h0, res_valid}, 64'h0);

        // Stall: SLL 1 by 63 held while consumer not ready
        res_ready = 1'b0;
        req1_a = 64'h1; req1_n = 6'd63; req1_op = 2'b00; req1_valid = 1'b1;
        #1;
        chk("C_ready1", {63'h0, req1_ready}, 64'h1);
        push(1'b1, 64'h8000_0000_0000_0000);
        step();
        req0_valid = 1'b1; req0_a = 64'h5; req0_n = 6'd1; req0_op = 2'b00;
        req1_a = 64'h7;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("C_ready0", {63'h0, req0_ready}, 64'h0);
            chk("C_ready1_low", {63'h0, req1_ready}, 64'h0);
            chk("C_res_valid", {63'h0, res_valid}, 64'h1);
            chk("C_res_data", res_data, 64'h8000_0000_0000_0000);
            chk("C_res_id", {63'h0, res_id}, 64'h1);
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("C_idle", {63'h0, res_valid}, 64'h0);

        // n=0 passthrough, reserved op, SRA by 63
        res_ready = 1'b1;
        req0_a = 64'hFFFF_FFFF_FFFF_FFFF; req0_n = 6'd0; req0_op = 2'b01; req0_valid = 1'b1;
        push(1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        step();
        req0_valid = 1'b0;
        req1_a = 64'h1234_5678_9ABC_DEF0; req1_n = 6'd5; req1_op = 2'b11; req1_valid = 1'b1;
        push(1'b1, 64'h0);
        step();
        req1_valid = 1'b0;
        req0_a = 64'h8000_0000_0000_0000; req0_n = 6'd63; req0_op = 2'b10; req0_valid = 1'b1;
        push(1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        step();
        req0_valid = 1'b0;
        step();
        chk("D_gnt0", {48'h0, gnt0_cnt}, 64'h4);
        chk("D_gnt1", {48'h0, gnt1_cnt}, 64'h4);
        chk("D_idle", {63'h0, res_valid}, 64'h0);

        // Reset while holding a stalled result
        res_ready = 1'b0;
        req0_a = 64'h3; req0_n = 6'd1; req0_op = 2'b00; req0_valid = 1'b1;
        step();
        req0_valid = 1'b0;
        req1_a = 64'h80; req1_n = 6'd7; req1_op = 2'b01; req1_valid = 1'b1;
        #1;
        chk("E_hold_ready1", {63'h0, req1_ready}, 64'h0);
        reset = 1'b1;
        #1;
        chk("E_rst_ready1", {63'h0, req1_ready}, 64'h0);
        step();
        chk("E_res_valid", {63'h0, res_valid}, 64'h0);
        chk("E_res_data", res_data, 64'h0);
        chk("E_gnt0", {48'h0, gnt0_cnt}, 64'h0);
        chk("E_gnt1", {48'h0, gnt1_cnt}, 64'h0);
        chk("E_rst2_ready1", {63'h0, req1_ready}, 64'h0);
        reset = 1'b0;
        #1;
        chk("E_post_ready1", {63'h0, req1_ready}, 64'h1);
        req0_valid = 1'b1; res_ready = 1'b1;
        #1;
        chk("E_rr_ready0", {63'h0, req0_ready}, 64'h1);
        chk("E_rr_ready1", {63'h0, req1_ready}, 64'h0);
        push(1'b0, 64'h6);
        step();
        req0_valid = 1'b0;
        #1;
        chk("E_ready1_next", {63'h0, req1_ready}, 64'h1);
        push(1'b1, 64'h1);
        step();
        req1_valid = 1'b0;
        step();
        chk("E_gnt0_after", {48'h0, gnt0_cnt}, 64'h1);
        chk("E_gnt1_after", {48'h0, gnt1_cnt}, 64'h1);
        chk("E_idle", {63'h0, res_valid}, 64'h0);

        // Counter saturation with CNT_W=2
        rst2 = 1'b0; v2 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("F_sat_cnt", {62'h0, d2_cnt0}, {62'h0, sat_exp[k]});
        end
        v2 = 1'b0;

        step();
        chk("sb_empty", 64'(sb_q.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
